// File: rtl/minmax_tracker.sv
// minmax_tracker: block min/max tracker over a valid/ready sample stream.
// comp_2n is the shared magnitude comparator. It is built from 2-bit slices
// and handles both unsigned and two's-complement operands.

// comp_2n: strict a > b over N 2-bit slices, with an optional signed mode.
// Only the strict relation is exported. The min path calls it with swapped
// operands, so equal operands never produce an update on either path.
module comp_2n #(
  parameter int N = 2
) (
  input  logic           neg,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           gt
);

  logic [2*N-1:0] ax;
  logic [2*N-1:0] bx;
  logic [N-1:0]   gt_s;
  logic [N-1:0]   eq_s;

  // Signed mode: flipping both sign bits maps two's-complement onto offset
  // binary, so the unsigned slice chain below orders the values correctly.
  always_comb begin
    ax = a;
    bx = b;
    ax[2*N-1] = a[2*N-1] ^ neg;
    bx[2*N-1] = b[2*N-1] ^ neg;
  end

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign gt_s[i] = (ax[2*i +: 2] > bx[2*i +: 2]);
    assign eq_s[i] = (ax[2*i +: 2] == bx[2*i +: 2]);
  end

  // Resolve the slices starting from the MSB. The first slice that differs decides.
  always_comb begin
    logic above_eq;
    gt       = 1'b0;
    above_eq = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      gt       = gt | (above_eq & gt_s[i]);
      above_eq = above_eq & eq_s[i];
    end
  end

endmodule

// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; result registers hold the last block
//   S_FIRST | in_ready=1, the first sample seeds both max and min
//   S_RUN   | in_ready=1, track max/min until LEN samples are accepted
//   S_DONE  | out_valid=1, the result is held until out_ack
module minmax_tracker #(
  parameter int N   = 2,
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           neg,
  input  logic           in_valid,
  input  logic [2*N-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ack,
  output logic [2*N-1:0] max_o,
  output logic [2*N-1:0] min_o,
  output logic [7:0]     count_o
);

  localparam int W = 2 * N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LEN_C = 8'(LEN);

  logic [1:0]   state;
  logic         neg_q;
  logic [W-1:0] max_q;
  logic [W-1:0] min_q;
  logic [7:0]   count_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic         accept;
  logic         upd_max;
  logic         upd_min;
  logic [7:0]   count_nx;

  assign accept   = in_valid & in_ready_q;
  assign count_nx = count_q + 8'd1;

  // sample > max
  comp_2n #(.N(N)) u_cmp_max (
    .neg (neg_q),
    .a   (in_data),
    .b   (max_q),
    .gt  (upd_max)
  );

  // min > sample, which is the same as sample < min
  comp_2n #(.N(N)) u_cmp_min (
    .neg (neg_q),
    .a   (min_q),
    .b   (in_data),
    .gt  (upd_min)
  );

  // Block sequencer. The handshake flags and the result are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      neg_q       <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            neg_q      <= neg;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            state      <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (accept) begin
            max_q   <= in_data;
            min_q   <= in_data;
            count_q <= 8'd1;
            if (LEN_C == 8'd1) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (upd_max) max_q <= in_data;
            if (upd_min) min_q <= in_data;
            count_q <= count_nx;
            if (count_nx == LEN_C) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ack) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign max_o     = max_q;
  assign min_o     = min_q;
  assign count_o   = count_q;

endmodule
